// File: rtl/sar_mag_search.sv
// -----------------------------------------------------------------------------
// sar_mag_search
//
// Binary-search engine that drives the A side of a W-bit magnitude comparator
// whose B side is tied to an unknown target. It presents a probe value on
// `guess`, reads back AeqB/AgtB/AltB in the same cycle, and narrows the search
// window [lo, hi] until the comparator reports equality. If the comparator
// misbehaves, the search ends with `err`. This covers flag combinations that
// are not one-hot, a window that cannot shrink further, and running out of
// probes.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       begin a search (sampled only in IDLE)
//   AeqB        comparator: guess == target
//   AgtB        comparator: guess >  target
//   AltB        comparator: guess <  target
//   guess       registered probe value, drives comparator A
//   busy        high while probing
//   done        one-cycle pulse marking the end of a search
//   found       last search ended on equality
//   err         last search ended on protocol error or timeout
//   result      matched value, valid when found=1
//   probes      number of comparisons used by the last search
//   dbg_state_o current FSM state (0=IDLE, 1=PROBE, 2=DONE)
//
// Handshake: `start` is a single-cycle request. It is accepted only in IDLE.
// Requests made in PROBE or DONE are dropped, not queued. Completion is
// signalled by `done`, which is high for exactly one cycle. The status outputs
// (found/err/result/probes/guess) hold their values until the next accepted
// start.
// -----------------------------------------------------------------------------
module sar_mag_search #(
  parameter int W  = 4,
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          AeqB,
  input  logic          AgtB,
  input  logic          AltB,
  output logic [W-1:0]  guess,
  output logic          busy,
  output logic          done,
  output logic          found,
  output logic          err,
  output logic [W-1:0]  result,
  output logic [CW-1:0] probes,
  output logic [1:0]    dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PROBE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  // First probe is the midpoint of the full range.
  localparam logic [W-1:0]  FIRST_GUESS = W'((2**W - 1) >> 1);
  // A consistent comparator needs at most W+1 probes.
  localparam logic [CW-1:0] MAX_PROBES  = CW'(W + 1);

  state_t        state_q,  state_d;
  logic [W-1:0]  guess_q,  guess_d;
  logic [W-1:0]  lo_q,     lo_d;
  logic [W-1:0]  hi_q,     hi_d;
  logic [W-1:0]  result_q, result_d;
  logic [CW-1:0] probes_q, probes_d;
  logic          found_q,  found_d;
  logic          err_q,    err_d;

  logic [CW-1:0] probes_inc;
  logic [W-1:0]  guess_dec;
  logic [W-1:0]  guess_inc;
  // Window sums are formed one bit wider so the midpoint never wraps.
  logic [W:0]    sum_gt;
  logic [W:0]    sum_lt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      guess_q  <= '0;
      lo_q     <= '0;
      hi_q     <= '0;
      result_q <= '0;
      probes_q <= '0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      lo_q     <= lo_d;
      hi_q     <= hi_d;
      result_q <= result_d;
      probes_q <= probes_d;
      found_q  <= found_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    guess_d    = guess_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    result_d   = result_q;
    probes_d   = probes_q;
    found_d    = found_q;
    err_d      = err_q;

    probes_inc = probes_q + CW'(1);
    guess_dec  = guess_q - W'(1);
    guess_inc  = guess_q + W'(1);
    // Target is below guess: the new window is [lo, guess-1].
    sum_gt     = {1'b0, lo_q} + {1'b0, guess_dec};
    // Target is above guess: the new window is [guess+1, hi].
    sum_lt     = {1'b0, guess_inc} + {1'b0, hi_q};

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          lo_d     = '0;
          hi_d     = '1;
          guess_d  = FIRST_GUESS;
          probes_d = '0;
          found_d  = 1'b0;
          err_d    = 1'b0;
          state_d  = S_PROBE;
        end
      end

      S_PROBE: begin
        probes_d = probes_inc;
        unique case ({AeqB, AgtB, AltB})
          3'b100: begin
            // Equality wins even on the last allowed probe.
            result_d = guess_q;
            found_d  = 1'b1;
            state_d  = S_DONE;
          end
          3'b010: begin
            // guess == lo means the target would lie below the window.
            if (probes_inc == MAX_PROBES || guess_q == lo_q) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              hi_d    = guess_dec;
              guess_d = W'(sum_gt >> 1);
            end
          end
          3'b001: begin
            // guess == hi means the target would lie above the window.
            if (probes_inc == MAX_PROBES || guess_q == hi_q) begin
              err_d   = 1'b1;
              state_d = S_DONE;
            end else begin
              lo_d    = guess_inc;
              guess_d = W'(sum_lt >> 1);
            end
          end
          default: begin
            // No flag or more than one flag: the comparator is not one-hot.
            err_d   = 1'b1;
            state_d = S_DONE;
          end
        endcase
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign guess       = guess_q;
  assign result      = result_q;
  assign probes      = probes_q;
  assign found       = found_q;
  assign err         = err_q;
  assign busy        = (state_q == S_PROBE);
  assign done        = (state_q == S_DONE);
  assign dbg_state_o = state_q;

endmodule
